hub75_bcm_driver: RTL
=====================

Name: hub75_bcm_driver

Overview:
Parametrised successor of the fixed-size HUB75 LED matrix driver: scans a 1:2^ROW_BITS multiplexed panel of COLS columns. Uses binary-coded modulation (BCM) to show BPC bits per colour channel. Reads pixel pairs (upper/lower half) from an external synchronous frame-buffer RAM. Sits between the frame-buffer and the panel connector pins at top level.

Parameters:
BASE_FREQ, 12000000, CLK_I frequency in Hz
TARGET_FREQ, 6000000, CLK_O shift frequency in Hz; HALF = BASE_FREQ/(2*TARGET_FREQ), must be >= 1 (elaboration error otherwise)
COLS, 64, columns per row; power of two, >= 2
ROW_BITS, 4, scan-row address width (rows = 2^ROW_BITS; panel height = 2*rows)
BPC, 4, bits per colour channel (BCM planes), 1..8
BASE_OE, 8, display ticks for plane 0; plane p displays BASE_OE<<p ticks

Ports:
CLK_I  in  1  system clock, single clock domain
RST_I  in  1  synchronous reset, active-high
ADDR_O  out  ROW_BITS+log2(COLS)  frame-buffer read address {row, col}
DAT_I  in  6*BPC  pixel pair {R1,G1,B1,R0,G0,B0}, BPC bits each, MSB first; valid one CLK_I cycle after ADDR_O
R0,G0,B0,R1,G1,B1  out  1 each  serial colour data, upper/lower half
ROW_O  out  ROW_BITS  row select to panel (RA,RB,...)
CLK_O  out  1  shift clock; panel samples on rising edge
LATCH  out  1  active-high latch strobe
OE  out  1  output enable, active-low (1 = blanked)
FRAME_O  out  1  one-CLK_I pulse at end of each full frame

Behaviour:
- Reset (RST_I=1 at CLK_I edge): colour outputs 0, CLK_O 0, LATCH 0, OE 1, ROW_O 0, ADDR_O 0, FRAME_O 0; FSM -> SHIFT, row 0, plane 0, col 0, tick counter 0. Reset mid-operation aborts immediately; no partial latch.
- tick: internal enable every HALF CLK_I cycles (HALF=1 -> every cycle). All FSM/pin updates happen on tick only.
- SHIFT: per column c: tick A drives colour bits = bit p of each channel, CLK_O=0; tick B sets CLK_O=1. After 2*COLS ticks -> BLANK. ADDR_O for column c is issued at least one CLK_I cycle before tick A of c (prefetch); DAT_I registered.
- BLANK: 1 tick, OE=1, CLK_O=0 -> LATCH.
- LATCH: 1 tick LATCH=1, ROW_O <= current row -> DISPLAY.
- DISPLAY: OE=0 for BASE_OE<<p ticks, then OE=1; next plane p+1 -> SHIFT. After plane BPC-1: row+1, plane 0. After last row (wrap 2^ROW_BITS-1 -> 0): FRAME_O=1 for one CLK_I cycle on the wrap.
- OE is always 1 during SHIFT, BLANK, LATCH (no ghosting); LATCH and OE=0 never coincide.
- Counter widths sized via $clog2; display counter wide enough for BASE_OE<<(BPC-1) without overflow.
- DAT_I changing outside its valid cycle is ignored.

Optional Feature:
BRIGHTNESS_EN: adds input BRIGHT_I [7:0]. In DISPLAY the window length is unchanged (BASE_OE<<p ticks) but OE=0 only for the first ((BASE_OE<<p)*BRIGHT_I)>>8 ticks, 1 for the rest; BRIGHT_I sampled at DISPLAY entry. BRIGHT_I=0 -> panel dark. Without macro: OE=0 for full window (equivalent to full brightness).

Decomposition:
- Shared include hub75_defs.vh: FSM state encodings (SHIFT, BLANK, LATCH, DISPLAY), DAT_I field offsets per channel, HALF computation macro.
- Sub-module hub75_tick_gen: parametrised divider producing the tick enable from BASE_FREQ/TARGET_FREQ, synchronous reset.

Test Plan:
(Bench config: COLS=4, ROW_BITS=1, BPC=2, BASE_OE=2, HALF=1; RAM model with 1-cycle latency.)
- Reset: hold RST_I 3 cycles -> OE=1, LATCH=0, CLK_O=0, ROW_O=0, ADDR_O=0; first CLK_O rise within 3 cycles of release.
- Shift data: RAM row0 R0 = {2'b01,2'b00,2'b01,2'b00} -> plane 0 R0 sampled on CLK_O rises = 1,0,1,0; plane 1 = 0,0,0,0.
- BCM timing: per row, OE=0 for exactly 2 ticks (plane 0) then 4 ticks (plane 1); exactly 4 CLK_O rises and one LATCH pulse precede each.
- Row/frame wrap: ROW_O goes 0,1,0; FRAME_O single pulse per 2 rows x 2 planes; no LATCH while OE=0.
- Reset mid-DISPLAY of row 1 plane 1 -> next cycle OE=1, ROW_O=0, restart at row 0 plane 0.
- BRIGHTNESS_EN, BRIGHT_I=128 -> plane 1 OE=0 for 2 of 4 ticks; BRIGHT_I=0 -> OE never 0.

Source files
------------

// File: rtl/hub75_bcm_driver_pkg.sv
// Shared definitions for the HUB75 BCM driver: FSM state codes, DAT_I channel slots, tick divider helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package hub75_bcm_driver_pkg;

    // Scan FSM state encodings.
    localparam logic [1:0] ST_SHIFT   = 2'd0;
    localparam logic [1:0] ST_BLANK   = 2'd1;
    localparam logic [1:0] ST_LATCH   = 2'd2;
    localparam logic [1:0] ST_DISPLAY = 2'd3;

    // Channel slot numbers inside a DAT_I word {R1,G1,B1,R0,G0,B0}.
    // Each slot is BPC bits wide, so the slot's LSB sits at ch*BPC.
    localparam int CH_B0 = 0;
    localparam int CH_G0 = 1;
    localparam int CH_R0 = 2;
    localparam int CH_B1 = 3;
    localparam int CH_G1 = 4;
    localparam int CH_R1 = 5;

    // Number of CLK_I cycles per half period of the shift clock.
    function automatic int half_div(input int base_freq, input int target_freq);
        return base_freq / (2 * target_freq);
    endfunction

endpackage

// File: rtl/hub75_tick_gen.sv
// Tick enable divider: pulses tick once every HALF clk cycles (every cycle when HALF == 1).
// Latency: first tick HALF cycles after reset release; output is a decode of the count register.
// Backpressure: none, free-running.
// Ports: clk (clock), rst (sync active-high reset), tick (one-cycle enable).
module hub75_tick_gen #(
    parameter int HALF = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(HALF - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 panel scanner with binary-coded modulation, fed from a synchronous frame-buffer RAM.
// Latency: pixel read issued >= 2 CLK_I cycles before it is shifted; one CLK_O edge per tick.
// Backpressure: none; a missing pixel read only stalls the first shift tick after reset.
// Ports: CLK_I/RST_I clock and sync reset; ADDR_O/DAT_I frame-buffer read port ({row,col}, 1-cycle
//        latency); R0..B1 serial colour; ROW_O row select; CLK_O shift clock; LATCH strobe;
//        OE active-low enable; FRAME_O end-of-frame pulse.
// Optional macro BRIGHTNESS_EN adds BRIGHT_I[7:0], scaling the lit part of each display window.
module hub75_bcm_driver #(
    parameter int BASE_FREQ   = 12000000,
    parameter int TARGET_FREQ = 6000000,
    parameter int COLS        = 64,
    parameter int ROW_BITS    = 4,
    parameter int BPC         = 4,
    parameter int BASE_OE     = 8
) (
    input  logic                               CLK_I,
    input  logic                               RST_I,
    output logic [ROW_BITS+$clog2(COLS)-1:0]   ADDR_O,
    input  logic [6*BPC-1:0]                   DAT_I,
`ifdef BRIGHTNESS_EN
    input  logic [7:0]                         BRIGHT_I,
`endif
    output logic                               R0,
    output logic                               G0,
    output logic                               B0,
    output logic                               R1,
    output logic                               G1,
    output logic                               B1,
    output logic [ROW_BITS-1:0]                ROW_O,
    output logic                               CLK_O,
    output logic                               LATCH,
    output logic                               OE,
    output logic                               FRAME_O
);

    import hub75_bcm_driver_pkg::*;

    localparam int HALF = half_div(BASE_FREQ, TARGET_FREQ);
    localparam int CW   = $clog2(COLS);
    localparam int PW   = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int MAXN = BASE_OE << (BPC - 1);
    localparam int DW   = $clog2(MAXN + 1);

    generate
        if (HALF < 1) begin : g_bad_half
            $error("hub75_bcm_driver: BASE_FREQ/(2*TARGET_FREQ) must be >= 1");
        end
    endgenerate

    logic                tick;
    logic [1:0]          state;
    logic                phase;      // 0: next tick presents data, 1: next tick raises CLK_O
    logic [CW-1:0]       col;
    logic [CW-1:0]       col_nxt;
    logic [ROW_BITS-1:0] row;
    logic [ROW_BITS-1:0] row_nxt;    // row of the segment following the current one
    logic [PW-1:0]       plane;
    logic                last_plane;
    logic [DW-1:0]       disp_cnt;
    logic [DW-1:0]       win_len;
    logic [DW-1:0]       on_len;
    logic                rd_s1;      // read address presented this cycle
    logic                rd_s2;      // DAT_I carries that read's data this cycle
    logic [6*BPC-1:0]    pix_reg;
    logic                pix_vld;
    logic [6*BPC-1:0]    pix_use;
    logic [5:0]          plane_bits;

    hub75_tick_gen #(
        .HALF (HALF)
    ) u_tick (
        .clk  (CLK_I),
        .rst  (RST_I),
        .tick (tick)
    );

    assign col_nxt    = col + 1'b1;
    assign last_plane = (plane == PW'(BPC - 1));
    assign row_nxt    = last_plane ? row + 1'b1 : row;
    assign win_len    = DW'(BASE_OE) << plane;

    // The data for a column can land on the very edge that shifts it out
    // (HALF == 1), so bypass the capture register in that cycle.
    assign pix_use = rd_s2 ? DAT_I : pix_reg;

    generate
        for (genvar k = 0; k < 6; k++) begin : g_ch
            logic [BPC-1:0] fld;
            assign fld           = pix_use[k*BPC +: BPC];
            assign plane_bits[k] = fld[plane];
        end
    endgenerate

`ifdef BRIGHTNESS_EN
    logic [DW+7:0] bright_prod;
    assign bright_prod = {8'b0, win_len} * {{DW{1'b0}}, BRIGHT_I};
`endif

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state    <= ST_SHIFT;
            phase    <= 1'b0;
            col      <= '0;
            row      <= '0;
            plane    <= '0;
            disp_cnt <= '0;
            on_len   <= '0;
            // Address 0 is on the bus during reset, so its read counts as issued.
            rd_s1    <= 1'b1;
            rd_s2    <= 1'b0;
            pix_reg  <= '0;
            pix_vld  <= 1'b0;
            ADDR_O   <= '0;
            R0       <= 1'b0;
            G0       <= 1'b0;
            B0       <= 1'b0;
            R1       <= 1'b0;
            G1       <= 1'b0;
            B1       <= 1'b0;
            ROW_O    <= '0;
            CLK_O    <= 1'b0;
            LATCH    <= 1'b0;
            OE       <= 1'b1;
            FRAME_O  <= 1'b0;
        end else begin
            FRAME_O <= 1'b0;
            rd_s1   <= 1'b0;
            rd_s2   <= rd_s1;
            // DAT_I is only looked at in the cycle its read returns.
            if (rd_s2) begin
                pix_reg <= DAT_I;
                pix_vld <= 1'b1;
            end

            if (tick) begin
                case (state)
                    ST_SHIFT: begin
                        if (!phase) begin
                            if (pix_vld || rd_s2) begin
                                R0      <= plane_bits[CH_R0];
                                G0      <= plane_bits[CH_G0];
                                B0      <= plane_bits[CH_B0];
                                R1      <= plane_bits[CH_R1];
                                G1      <= plane_bits[CH_G1];
                                B1      <= plane_bits[CH_B1];
                                CLK_O   <= 1'b0;
                                OE      <= 1'b1;
                                phase   <= 1'b1;
                                pix_vld <= 1'b0;
                                // Prefetch the next column while this one is clocked in.
                                if (col != CW'(COLS - 1)) begin
                                    ADDR_O <= {row, col_nxt};
                                    rd_s1  <= 1'b1;
                                end
                            end
                        end else begin
                            CLK_O <= 1'b1;
                            phase <= 1'b0;
                            if (col == CW'(COLS - 1)) begin
                                col   <= '0;
                                state <= ST_BLANK;
                            end else begin
                                col <= col_nxt;
                            end
                        end
                    end
                    ST_BLANK: begin
                        CLK_O  <= 1'b0;
                        OE     <= 1'b1;
                        // Column 0 of the next segment, well ahead of its first shift tick.
                        ADDR_O <= {row_nxt, {CW{1'b0}}};
                        rd_s1  <= 1'b1;
                        state  <= ST_LATCH;
                    end
                    ST_LATCH: begin
                        LATCH    <= 1'b1;
                        ROW_O    <= row;
                        disp_cnt <= '0;
`ifdef BRIGHTNESS_EN
                        on_len   <= bright_prod[DW+7:8];
`else
                        on_len   <= win_len;
`endif
                        state    <= ST_DISPLAY;
                    end
                    default: begin // ST_DISPLAY
                        LATCH <= 1'b0;
                        if (disp_cnt == win_len) begin
                            OE    <= 1'b1;
                            state <= ST_SHIFT;
                            if (last_plane) begin
                                plane <= '0;
                                row   <= row + 1'b1;
                                if (row == {ROW_BITS{1'b1}}) begin
                                    FRAME_O <= 1'b1;
                                end
                            end else begin
                                plane <= plane + 1'b1;
                            end
                        end else begin
                            OE       <= !(disp_cnt < on_len);
                            disp_cnt <= disp_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
